// File: rtl/hb_dq_rx_gearbox.sv
// HyperBus DQ receive gearbox: realigns the capture strobe, packs 16-bit bus words into
// WORD_RATIO-word beats and queues them in a beat FIFO with tlast/overflow tracking.
module hb_dq_rx_gearbox #(
    parameter int DQ_WIDTH    = 8,
    parameter int WORD_RATIO  = 2,
    parameter int VLD_LATENCY = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                               iddr_clk,
    input  logic                               arst_n,
    input  logic                               rx_start,
    input  logic [15:0]                        rx_len,
    input  logic [2*DQ_WIDTH-1:0]              dq_sdr,
    input  logic                               dq_sdr_en,
    output logic [2*DQ_WIDTH*WORD_RATIO-1:0]   m_tdata,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic                               m_tlast,
    output logic                               busy,
    output logic                               overflow
);
    localparam int WORD_W = 2 * DQ_WIDTH;
    localparam int BEAT_W = WORD_W * WORD_RATIO;
    localparam int IDX_W  = (WORD_RATIO > 1) ? $clog2(WORD_RATIO) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

    logic [VLD_LATENCY-1:0] en_pipe_q, en_pipe_d;
    logic                   en_tail;
    logic [WORD_W-1:0]      word;
    logic [BEAT_W-1:0]      beat_ins;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               start_ok, push, push_last;
    logic [BEAT_W-1:0]  push_data;

    logic [BEAT_W:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   mem_cnt_q, mem_cnt_d;
    logic               out_vld_q, out_last_q, ovf_q;
    logic [BEAT_W-1:0]  out_data_q;
    logic               pop, full, push_ok, drop, load;

    // Strobe delay line: the tail lines up with the IDDR output data.
    assign en_pipe_d[0] = dq_sdr_en;
    for (genvar gi = 1; gi < VLD_LATENCY; gi++) begin : g_en_pipe
        assign en_pipe_d[gi] = en_pipe_q[gi-1];
    end
    assign en_tail = en_pipe_q[VLD_LATENCY-1];

    always_ff @(posedge iddr_clk or negedge arst_n) begin
        if (!arst_n) en_pipe_q <= '0;
        else         en_pipe_q <= en_pipe_d;
    end

    // Rising-edge bits form the upper half of the word, falling-edge bits the lower half.
    for (genvar gi = 0; gi < DQ_WIDTH; gi++) begin : g_lane
        assign word[DQ_WIDTH+gi] = dq_sdr[2*gi+1];
        assign word[gi]          = dq_sdr[2*gi];
    end

    for (genvar gi = 0; gi < WORD_RATIO; gi++) begin : g_slot
        assign beat_ins[gi*WORD_W +: WORD_W] =
            (idx_q == IDX_W'(gi)) ? word : beat_q[gi*WORD_W +: WORD_W];
    end

    assign start_ok = rx_start && (rx_len != 16'd0);
    assign cnt_inc  = cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        idx_d     = idx_q;
        beat_d    = beat_q;
        push      = 1'b0;
        push_last = 1'b0;
        push_data = beat_ins;
        if (start_ok) begin
            // A restart abandons any partial or pending flush beat.
            state_d = RECV;
            cnt_d   = '0;
            len_d   = rx_len;
            idx_d   = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                RECV: begin
                    if (en_tail) begin
                        cnt_d = cnt_inc;
                        if (idx_q == IDX_W'(WORD_RATIO - 1)) begin
                            push      = 1'b1;
                            push_last = (cnt_inc == len_q);
                            idx_d     = '0;
                            beat_d    = '0;
                            if (cnt_inc == len_q) state_d = IDLE;
                        end else begin
                            beat_d = beat_ins;
                            idx_d  = idx_q + IDX_W'(1);
                            if (cnt_inc == len_q) state_d = FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    push      = 1'b1;
                    push_last = 1'b1;
                    push_data = beat_q;
                    beat_d    = '0;
                    idx_d     = '0;
                    state_d   = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iddr_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
        end
    end

    // Occupancy counts the memory plus the output register, so FIFO_DEPTH beats can be held.
    assign pop     = out_vld_q && m_tready;
    assign full    = (mem_cnt_q + CNT_W'(out_vld_q)) == CNT_W'(FIFO_DEPTH);
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign load    = (mem_cnt_q != '0) && (!out_vld_q || pop);

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        if (push_ok && !load)      mem_cnt_d = mem_cnt_q + CNT_W'(1);
        else if (!push_ok && load) mem_cnt_d = mem_cnt_q - CNT_W'(1);
    end

    always_ff @(posedge iddr_clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= {push_last, push_data};
    end

    always_ff @(posedge iddr_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (load) begin
                {out_last_q, out_data_q} <= fifo_mem[rd_ptr_q];
                out_vld_q                <= 1'b1;
                rd_ptr_q                 <= rd_ptr_q + PTR_W'(1);
            end else if (pop) begin
                out_vld_q <= 1'b0;
            end
            if (drop)          ovf_q <= 1'b1;
            else if (start_ok) ovf_q <= 1'b0;
        end
    end

    assign m_tdata  = out_data_q;
    assign m_tvalid = out_vld_q;
    assign m_tlast  = out_last_q;
    assign busy     = (state_q != IDLE);
    assign overflow = ovf_q;
endmodule

// File: tb/tb_hb_dq_rx_gearbox.sv
// Bench for hb_dq_rx_gearbox: one RATIO=2 instance plus RATIO=1 instances at latencies 1..4,
// all on shared stimulus, checked every cycle against a transfer-level model.
module tb_hb_dq_rx_gearbox;
    logic        clk = 1'b0;
    logic        arst_n, rx_start, dq_sdr_en, m_tready;
    logic [15:0] rx_len, dq_sdr;

    logic [31:0] td0;
    logic        tv0, tl0, by0, ov0;
    logic [15:0] td1 [4];
    logic        tv1 [4];
    logic        tl1 [4];
    logic        by1 [4];
    logic        ov1 [4];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hb_dq_rx_gearbox #(.DQ_WIDTH(8), .WORD_RATIO(2), .VLD_LATENCY(2), .FIFO_DEPTH(8)) u_dut (
        .iddr_clk(clk), .arst_n(arst_n), .rx_start(rx_start), .rx_len(rx_len),
        .dq_sdr(dq_sdr), .dq_sdr_en(dq_sdr_en), .m_tdata(td0), .m_tvalid(tv0),
        .m_tready(m_tready), .m_tlast(tl0), .busy(by0), .overflow(ov0));

    for (genvar gi = 0; gi < 4; gi++) begin : g_lat
        hb_dq_rx_gearbox #(.DQ_WIDTH(8), .WORD_RATIO(1), .VLD_LATENCY(gi+1), .FIFO_DEPTH(8)) u_dut (
            .iddr_clk(clk), .arst_n(arst_n), .rx_start(rx_start), .rx_len(rx_len),
            .dq_sdr(dq_sdr), .dq_sdr_en(dq_sdr_en), .m_tdata(td1[gi]), .m_tvalid(tv1[gi]),
            .m_tready(m_tready), .m_tlast(tl1[gi]), .busy(by1[gi]), .overflow(ov1[gi]));
    end

    // ---------------- model state (index 0: RATIO=2/LAT=2, 1..4: RATIO=1/LAT=k) ----------------
    logic [31:0] mq_data [5][64];
    bit          mq_last [5][64];
    int          mq_pcyc [5][64];
    int          hd [5], tl [5], last_pop [5];
    bit          act [5], fl [5], movf [5], prev_v [5];
    int          mcnt [5], mlen [5], pcnt [5];
    logic [15:0] part [5][4];
    bit          en_ring [16];
    int          npop [5], nlast [5], rise_cyc [5];
    logic [31:0] log0 [32];
    bit          loglast0 [32];
    logic [15:0] wv [8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic int ratio(int k); return (k == 0) ? 2 : 1; endfunction
    function automatic int lat(int k);   return (k == 0) ? 2 : k; endfunction

    function automatic logic [15:0] inter(logic [15:0] w);
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            d[2*i+1] = w[8+i];
            d[2*i]   = w[i];
        end
        return d;
    endfunction

    function automatic logic [15:0] deint(logic [15:0] d);
        logic [15:0] w;
        for (int i = 0; i < 8; i++) begin
            w[8+i] = d[2*i+1];
            w[i]   = d[2*i];
        end
        return w;
    endfunction

    // Head beat becomes visible two cycles after its push, or the cycle after the previous pop.
    function automatic bit mvalid(int k);
        int r;
        if (tl[k] == hd[k]) return 1'b0;
        r = mq_pcyc[k][hd[k] & 63] + 2;
        if (last_pop[k] + 1 > r) r = last_pop[k] + 1;
        return cyc >= r;
    endfunction

    function automatic logic [31:0] massemble(int k);
        logic [31:0] b = '0;
        for (int i = 0; i < pcnt[k]; i++) b = b | (32'(part[k][i]) << (16 * i));
        return b;
    endfunction

    task automatic mpush(int k, logic [31:0] d, bit l);
        if (tl[k] - hd[k] == 8) begin
            movf[k] = 1'b1;
        end else begin
            mq_data[k][tl[k] & 63] = d;
            mq_last[k][tl[k] & 63] = l;
            mq_pcyc[k][tl[k] & 63] = cyc;
            tl[k]++;
        end
    endtask

    task automatic mstep(int k);
        bit cap;
        bit done;
        cap = en_ring[(cyc - lat(k)) & 15];
        if (rx_start && rx_len != 16'd0) begin
            act[k] = 1'b1; fl[k] = 1'b0; mcnt[k] = 0; mlen[k] = int'(rx_len);
            pcnt[k] = 0; movf[k] = 1'b0;
        end else if (fl[k]) begin
            mpush(k, massemble(k), 1'b1);
            fl[k] = 1'b0; pcnt[k] = 0;
        end else if (act[k] && cap) begin
            part[k][pcnt[k]] = deint(dq_sdr);
            pcnt[k]++;
            mcnt[k]++;
            done = (mcnt[k] == mlen[k]);
            if (pcnt[k] == ratio(k)) begin
                mpush(k, massemble(k), done);
                pcnt[k] = 0;
                act[k]  = !done;
            end else if (done) begin
                act[k] = 1'b0;
                fl[k]  = 1'b1;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            npop[k] = 0; nlast[k] = 0; rise_cyc[k] = -1; last_pop[k] = -100;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (!arst_n) begin
            chk("reset_tvalid", 32'(tv0), 32'd0);
            chk("reset_busy", 32'(by0), 32'd0);
            chk("reset_overflow", 32'(ov0), 32'd0);
            for (int k = 0; k < 5; k++) begin
                hd[k] = 0; tl[k] = 0; act[k] = 0; fl[k] = 0; movf[k] = 0;
                pcnt[k] = 0; last_pop[k] = -100; prev_v[k] = 0;
            end
            for (int i = 0; i < 16; i++) en_ring[i] = 1'b0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                logic        dv, dl, db, dov;
                logic [31:0] dd;
                bit          mv;
                if (k == 0) begin
                    dv = tv0; dd = td0; dl = tl0; db = by0; dov = ov0;
                end else begin
                    dv = tv1[k-1]; dd = {16'h0, td1[k-1]}; dl = tl1[k-1]; db = by1[k-1]; dov = ov1[k-1];
                end
                mv = mvalid(k);
                chk($sformatf("tvalid[%0d]", k), 32'(dv), 32'(mv));
                chk($sformatf("busy[%0d]", k), 32'(db), 32'(act[k] | fl[k]));
                chk($sformatf("overflow[%0d]", k), 32'(dov), 32'(movf[k]));
                if (mv) begin
                    chk($sformatf("tdata[%0d]", k), dd, mq_data[k][hd[k] & 63]);
                    chk($sformatf("tlast[%0d]", k), 32'(dl), 32'(mq_last[k][hd[k] & 63]));
                    if (m_tready) begin
                        if (k == 0) begin
                            log0[npop[0] & 31]     = dd;
                            loglast0[npop[0] & 31] = dl;
                            $display("beat %0d data=%h last=%0d cycle=%0d", npop[0], dd, dl, cyc);
                        end
                        npop[k]++;
                        if (dl) nlast[k]++;
                        hd[k]++;
                        last_pop[k] = cyc;
                    end
                end
                if (dv && !prev_v[k]) rise_cyc[k] = cyc;
                prev_v[k] = dv;
            end
            for (int k = 0; k < 5; k++) mstep(k);
            en_ring[cyc & 15] = dq_sdr_en;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start(input logic [15:0] len);
        rx_start = 1'b1;
        rx_len   = len;
        step();
        rx_start = 1'b0;
    endtask

    // Strobe for n cycles; wv[] appears on dq_sdr two cycles after each strobe.
    task automatic burst(input int n);
        for (int i = 0; i < n + 4; i++) begin
            dq_sdr_en = (i < n);
            dq_sdr    = (i >= 2 && i - 2 < n) ? inter(wv[(i >= 2) ? i - 2 : 0]) : inter(16'hA5A5 ^ 16'(i));
            step();
        end
        dq_sdr_en = 1'b0;
    endtask

    initial begin
        int b0, b2, bl0, bl2, c0;
        arst_n = 1'b0; rx_start = 1'b0; rx_len = '0; dq_sdr = '0; dq_sdr_en = 1'b0; m_tready = 1'b1;
        idle(3);
        arst_n = 1'b1;
        idle(2);
        chk("post_reset_tvalid", 32'(tv0), 32'd0);
        chk("post_reset_busy", 32'(by0), 32'd0);

        // len=4, two full beats
        wv[0] = 16'h0102; wv[1] = 16'h0304; wv[2] = 16'h0506; wv[3] = 16'h0708;
        b0 = npop[0];
        start(16'd4); burst(4); idle(6);
        chk("len4_count", 32'(npop[0] - b0), 32'd2);
        chk("len4_beat0", log0[b0 & 31], 32'h03040102);
        chk("len4_last0", 32'(loglast0[b0 & 31]), 32'd0);
        chk("len4_beat1", log0[(b0 + 1) & 31], 32'h07080506);
        chk("len4_last1", 32'(loglast0[(b0 + 1) & 31]), 32'd1);

        // len=3, partial flush
        b0 = npop[0];
        start(16'd3); burst(4); idle(6);
        chk("len3_count", 32'(npop[0] - b0), 32'd2);
        chk("len3_beat0", log0[b0 & 31], 32'h03040102);
        chk("len3_beat1", log0[(b0 + 1) & 31], 32'h00000506);
        chk("len3_last1", 32'(loglast0[(b0 + 1) & 31]), 32'd1);
        chk("len3_busy_after", 32'(by0), 32'd0);

        // overflow: consumer stalled, 20 words
        m_tready = 1'b0;
        start(16'd20);
        for (int i = 0; i < 24; i++) begin
            dq_sdr_en = (i < 20);
            dq_sdr    = inter(16'h1000 + 16'(i));
            step();
        end
        dq_sdr_en = 1'b0;
        idle(4);
        chk("ovf_r1_tvalid", 32'(tv1[1]), 32'd1);
        chk("ovf_r1_flag", 32'(ov1[1]), 32'd1);
        chk("ovf_r2_flag", 32'(ov0), 32'd1);
        b0 = npop[0]; b2 = npop[2]; bl0 = nlast[0]; bl2 = nlast[2];
        m_tready = 1'b1;
        idle(14);
        chk("ovf_r1_count", 32'(npop[2] - b2), 32'd8);
        chk("ovf_r1_lasts", 32'(nlast[2] - bl2), 32'd0);
        chk("ovf_r2_count", 32'(npop[0] - b0), 32'd8);
        chk("ovf_r2_lasts", 32'(nlast[0] - bl0), 32'd0);
        chk("ovf_sticky", 32'(ov0), 32'd1);

        // restart mid-transfer
        b0 = npop[0];
        wv[0] = 16'h1111;
        start(16'd4); burst(1);
        chk("restart_clears_ovf", 32'(ov0), 32'd0);
        wv[0] = 16'h2222; wv[1] = 16'h3333;
        start(16'd2); burst(2); idle(6);
        chk("restart_count", 32'(npop[0] - b0), 32'd1);
        chk("restart_beat", log0[b0 & 31], 32'h33332222);
        chk("restart_last", 32'(loglast0[b0 & 31]), 32'd1);

        // async reset with beats queued
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) wv[i] = 16'h4000 + 16'(i);
        start(16'd10); burst(6); idle(2);
        chk("pre_rst_tvalid", 32'(tv0), 32'd1);
        chk("pre_rst_busy", 32'(by0), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("arst_tvalid", 32'(tv0), 32'd0);
        chk("arst_busy", 32'(by0), 32'd0);
        chk("arst_overflow", 32'(ov0), 32'd0);
        idle(2);
        arst_n = 1'b1;
        b0 = npop[0];
        m_tready = 1'b1;
        idle(8);
        chk("post_arst_no_beat", 32'(npop[0] - b0), 32'd0);

        // zero-length start is ignored
        b0 = npop[0];
        start(16'd0); burst(3); idle(6);
        chk("len0_busy", 32'(by0), 32'd0);
        chk("len0_tvalid", 32'(tv0), 32'd0);
        chk("len0_count", 32'(npop[0] - b0), 32'd0);

        // latency sweep: single-word transfer on empty FIFO
        start(16'd1);
        c0 = cyc;
        dq_sdr_en = 1'b1;
        dq_sdr    = inter(16'hBEEF);
        step();
        dq_sdr_en = 1'b0;
        idle(12);
        for (int k = 1; k < 5; k++)
            chk($sformatf("latency_L%0d", k), 32'(rise_cyc[k]), 32'(c0 + k + 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
